dlx_multicycle_ctrl: RTL and testbench

Hardwired multi-cycle controller for the DLX datapath. Accepts one instruction (opcode/func) per handshake and steps it through DECODE, EXECUTE, MEMORY and WRITEBACK. It drives the 13-bit control word (rf1..wf1) one stage per cycle and stalls in MEMORY on a memory-ready handshake. It sits between instruction fetch and the datapath, replacing the single-cycle control word lookup.

---
 rtl/dlx_multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_dlx_multicycle_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dlx_multicycle_ctrl.sv
// Multi-cycle DLX controller: one instruction per handshake, stepped DECODE..WRITEBACK.
// Optional perf counters are built only when CTRL_PERF_CNT_EN is defined.
//
// state     | meaning
// IDLE      | instr_ready=1, waiting for instr_valid
// DECODE    | register file read, illegal detection
// EXECUTE   | ALU operation
// MEMORY    | load/store access, stalls on mem_ready with timeout
// WRITEBACK | register file write
module dlx_multicycle_ctrl #(
   parameter int FUNC_SIZE    = 11,
   parameter int OP_CODE_SIZE = 6,
   parameter int MEM_TIMEOUT  = 15,
   parameter int CNT_W        = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   input  logic [OP_CODE_SIZE-1:0] opcode,
   input  logic [FUNC_SIZE-1:0]    func,
   input  logic                    mem_ready,
   output logic                    rf1,
   output logic                    rf2,
   output logic                    en1,
   output logic                    s1,
   output logic                    s2,
   output logic                    alu1,
   output logic                    alu2,
   output logic                    en2,
   output logic                    rm,
   output logic                    wm,
   output logic                    en3,
   output logic                    s3,
   output logic                    wf1,
   output logic                    illegal,
   output logic                    mem_err,
   output logic [CNT_W-1:0]        retired_cnt,
   output logic [CNT_W-1:0]        stall_cnt
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_DECODE    = 3'd1;
   localparam logic [2:0] S_EXECUTE   = 3'd2;
   localparam logic [2:0] S_MEMORY    = 3'd3;
   localparam logic [2:0] S_WRITEBACK = 3'd4;

   localparam logic [OP_CODE_SIZE-1:0] OP_RTYPE = OP_CODE_SIZE'('h00);
   localparam logic [OP_CODE_SIZE-1:0] OP_ADDI  = OP_CODE_SIZE'('h08);
   localparam logic [OP_CODE_SIZE-1:0] OP_SUBI  = OP_CODE_SIZE'('h0A);
   localparam logic [OP_CODE_SIZE-1:0] OP_ANDI  = OP_CODE_SIZE'('h0C);
   localparam logic [OP_CODE_SIZE-1:0] OP_ORI   = OP_CODE_SIZE'('h0D);
   localparam logic [OP_CODE_SIZE-1:0] OP_NOP   = OP_CODE_SIZE'('h15);
   localparam logic [OP_CODE_SIZE-1:0] OP_LW    = OP_CODE_SIZE'('h23);
   localparam logic [OP_CODE_SIZE-1:0] OP_SW    = OP_CODE_SIZE'('h2B);

   localparam logic [FUNC_SIZE-1:0] F_ADD = FUNC_SIZE'('h20);
   localparam logic [FUNC_SIZE-1:0] F_SUB = FUNC_SIZE'('h22);
   localparam logic [FUNC_SIZE-1:0] F_AND = FUNC_SIZE'('h24);
   localparam logic [FUNC_SIZE-1:0] F_OR  = FUNC_SIZE'('h25);

   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   logic [2:0]              r_state;
   logic [2:0]              w_state_nxt;
   logic [OP_CODE_SIZE-1:0] r_opcode;
   logic [FUNC_SIZE-1:0]    r_func;
   logic [7:0]              r_wait;

   logic       w_rtype;
   logic       w_lw;
   logic       w_sw;
   logic       w_nop;
   logic       w_mem_acc;
   logic       w_legal;
   logic [1:0] w_alu;
   logic       w_stall;
   logic       w_timeout;

   // Decode works only from the latched instruction so outputs never follow live inputs.
   always_comb begin
      w_rtype = (r_opcode == OP_RTYPE);
      w_lw    = (r_opcode == OP_LW);
      w_sw    = (r_opcode == OP_SW);
      w_nop   = (r_opcode == OP_NOP);
      w_legal = 1'b0;
      w_alu   = 2'b00;
      case (r_opcode)
         OP_RTYPE: begin
            case (r_func)
               F_ADD:   begin w_legal = 1'b1; w_alu = 2'b00; end
               F_SUB:   begin w_legal = 1'b1; w_alu = 2'b01; end
               F_AND:   begin w_legal = 1'b1; w_alu = 2'b10; end
               F_OR:    begin w_legal = 1'b1; w_alu = 2'b11; end
               default: w_legal = 1'b0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: begin w_legal = 1'b1; w_alu = 2'b00; end
         OP_SUBI: begin w_legal = 1'b1; w_alu = 2'b01; end
         OP_ANDI: begin w_legal = 1'b1; w_alu = 2'b10; end
         OP_ORI:  begin w_legal = 1'b1; w_alu = 2'b11; end
         OP_NOP:  w_legal = 1'b1;
         default: w_legal = 1'b0;
      endcase
   end

   assign w_mem_acc = w_lw | w_sw;
   assign w_stall   = (r_state == S_MEMORY) && w_mem_acc && !mem_ready;
   assign w_timeout = w_stall && (r_wait == TIMEOUT_LAST);
   assign mem_err   = w_timeout;

   always_comb begin
      w_state_nxt = S_IDLE;
      case (r_state)
         S_IDLE:      w_state_nxt = instr_valid ? S_DECODE : S_IDLE;
         S_DECODE:    w_state_nxt = w_legal ? S_EXECUTE : S_IDLE;
         S_EXECUTE:   w_state_nxt = S_MEMORY;
         S_MEMORY: begin
            if (!w_mem_acc || mem_ready) w_state_nxt = S_WRITEBACK;
            else if (w_timeout)          w_state_nxt = S_IDLE;
            else                         w_state_nxt = S_MEMORY;
         end
         S_WRITEBACK: w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_opcode <= '0;
         r_func   <= '0;
         r_wait   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && instr_valid) begin
            r_opcode <= opcode;
            r_func   <= func;
         end
         if (w_stall && !w_timeout) r_wait <= r_wait + 8'd1;
         else                       r_wait <= '0;
      end
   end

   always_comb begin
      {rf1, rf2, en1, s1, s2, alu1, alu2, en2, rm, wm, en3, s3, wf1, illegal} = '0;
      instr_ready = (r_state == S_IDLE);
      case (r_state)
         S_DECODE: begin
            rf1     = 1'b1;
            en1     = 1'b1;
            rf2     = w_rtype | w_sw;
            illegal = !w_legal;
         end
         S_EXECUTE: begin
            if (!w_nop) begin
               en2          = 1'b1;
               s1           = 1'b1;
               s2           = !w_rtype;
               {alu1, alu2} = w_alu;
            end
         end
         S_MEMORY: begin
            if (!w_nop) begin
               en3 = 1'b1;
               rm  = w_lw;
               wm  = w_sw;
            end
         end
         S_WRITEBACK: begin
            wf1 = !w_sw && !w_nop;
            s3  = w_lw;
         end
         default: ;
      endcase
   end

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] r_retired;
   logic [CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_retired   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (r_state == S_WRITEBACK) r_retired <= r_retired + 1'b1;
         if (w_stall)                r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign retired_cnt = r_retired;
   assign stall_cnt   = r_stall_cnt;
`else
   assign retired_cnt = '0;
   assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_dlx_multicycle_ctrl.sv
// Directed, table-driven bench for dlx_multicycle_ctrl plus hand-written stall/timeout/reset sequences.
module tb_dlx_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [5:0]  opcode;
   logic [10:0] func;
   logic        mem_ready;
   logic        rf1, rf2, en1, s1, s2, alu1, alu2, en2, rm, wm, en3, s3, wf1;
   logic        illegal, mem_err;
   logic [15:0] retired_cnt, stall_cnt;

   dlx_multicycle_ctrl #(
      .FUNC_SIZE(11), .OP_CODE_SIZE(6), .MEM_TIMEOUT(15), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .func(func), .mem_ready(mem_ready),
      .rf1(rf1), .rf2(rf2), .en1(en1), .s1(s1), .s2(s2), .alu1(alu1), .alu2(alu2),
      .en2(en2), .rm(rm), .wm(wm), .en3(en3), .s3(s3), .wf1(wf1),
      .illegal(illegal), .mem_err(mem_err),
      .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Output word: {ready, rf1 rf2 en1, s1 s2 alu1 alu2 en2, rm wm en3, s3 wf1, illegal, mem_err}
   localparam logic [15:0] E_IDLE   = 16'b1_000_00000_000_00_0_0;
   localparam logic [15:0] ALL      = 16'hFFFF;
   localparam logic [15:0] ILL_CARE = 16'b1_000_11111_111_11_1_1;

   typedef struct {
      string       name;
      logic        rst;
      logic        valid;
      logic [5:0]  op;
      logic [10:0] func;
      logic        mrdy;
      logic [15:0] exp;
      logic [15:0] care;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_err    = 0;

   function automatic logic [15:0] outs();
      return {instr_ready, rf1, rf2, en1, s1, s2, alu1, alu2, en2, rm, wm, en3, s3, wf1,
              illegal, mem_err};
   endfunction

   task automatic cyc(input string name, input logic r, input logic v, input logic [5:0] o,
                      input logic [10:0] f, input logic m, input logic [15:0] exp,
                      input logic [15:0] care);
      rst = r; instr_valid = v; opcode = o; func = f; mem_ready = m;
      @(negedge clk);
      if (care != 16'h0) begin
         n_checks++;
         if ((outs() & care) !== (exp & care)) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (care %b)", name, outs(), exp, care);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string name, input int ret, input int stl);
      int er, es;
`ifdef CTRL_PERF_CNT_EN
      er = ret; es = stl;
`else
      er = 0; es = 0;
`endif
      n_checks++;
      if (retired_cnt !== 16'(er) || stall_cnt !== 16'(es)) begin
         n_err++;
         $display("FAIL %s: got retired=%0d stall=%0d expected retired=%0d stall=%0d",
                  name, retired_cnt, stall_cnt, er, es);
      end
   endtask

   task automatic push(input string name, input logic r, input logic v, input logic [5:0] o,
                       input logic [10:0] f, input logic m, input logic [15:0] exp,
                       input logic [15:0] care);
      vec_t e;
      e.name = name; e.rst = r; e.valid = v; e.op = o; e.func = f; e.mrdy = m;
      e.exp = exp; e.care = care;
      vecs.push_back(e);
   endtask

   // Handshake + DECODE/EXECUTE/MEMORY/WRITEBACK; live opcode is junk after the handshake.
   task automatic push_instr(input string name, input logic [5:0] op, input logic [10:0] f,
                             input logic [2:0] dec, input logic [4:0] ex,
                             input logic [2:0] mem, input logic [1:0] wb);
      push({name, "_hs"},  1'b0, 1'b1, op,    f,     1'b1, E_IDLE, ALL);
      push({name, "_dec"}, 1'b0, 1'b1, 6'h3F, 11'h0, 1'b1, {1'b0, dec, 5'b0, 3'b0, 2'b0, 2'b0}, ALL);
      push({name, "_ex"},  1'b0, 1'b1, 6'h3F, 11'h0, 1'b1, {1'b0, 3'b0, ex, 3'b0, 2'b0, 2'b0}, ALL);
      push({name, "_mem"}, 1'b0, 1'b1, 6'h3F, 11'h0, 1'b0, {1'b0, 3'b0, 5'b0, mem, 2'b0, 2'b0}, ALL);
      push({name, "_wb"},  1'b0, 1'b0, 6'h00, 11'h0, 1'b0, {1'b0, 3'b0, 5'b0, 3'b0, wb, 2'b0}, ALL);
   endtask

   initial begin
      rst = 1'b1; instr_valid = 1'b0; opcode = '0; func = '0; mem_ready = 1'b0;

      push("rst0",     1'b1, 1'b0, 6'h00, 11'h0, 1'b0, E_IDLE, 16'h0);
      push("rst1",     1'b1, 1'b0, 6'h00, 11'h0, 1'b0, E_IDLE, ALL);
      push("post_rst", 1'b0, 1'b0, 6'h00, 11'h0, 1'b0, E_IDLE, ALL);
      push_instr("add",  6'h00, 11'h20, 3'b111, 5'b10001, 3'b001, 2'b01);
      push_instr("sub",  6'h00, 11'h22, 3'b111, 5'b10011, 3'b001, 2'b01);
      push_instr("and",  6'h00, 11'h24, 3'b111, 5'b10101, 3'b001, 2'b01);
      push_instr("or",   6'h00, 11'h25, 3'b111, 5'b10111, 3'b001, 2'b01);
      push_instr("addi", 6'h08, 11'h0,  3'b101, 5'b11001, 3'b001, 2'b01);
      push_instr("subi", 6'h0A, 11'h0,  3'b101, 5'b11011, 3'b001, 2'b01);
      push_instr("andi", 6'h0C, 11'h0,  3'b101, 5'b11101, 3'b001, 2'b01);
      push_instr("ori",  6'h0D, 11'h0,  3'b101, 5'b11111, 3'b001, 2'b01);
      push_instr("nop",  6'h15, 11'h0,  3'b101, 5'b00000, 3'b000, 2'b00);
      push("lw_hs",   1'b0, 1'b1, 6'h23, 11'h0, 1'b0, E_IDLE, ALL);
      push("lw_dec",  1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_101_00000_000_00_0_0, ALL);
      push("lw_ex",   1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_11001_000_00_0_0, ALL);
      push("lw_m1",   1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_00000_101_00_0_0, ALL);
      push("lw_m2",   1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_00000_101_00_0_0, ALL);
      push("lw_m3",   1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_00000_101_00_0_0, ALL);
      push("lw_m4",   1'b0, 1'b0, 6'h00, 11'h0, 1'b1, 16'b0_000_00000_101_00_0_0, ALL);
      push("lw_wb",   1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_00000_000_11_0_0, ALL);
      push("ill1_hs", 1'b0, 1'b1, 6'h3F, 11'h0,  1'b0, E_IDLE, ALL);
      push("ill1_dec",1'b0, 1'b0, 6'h00, 11'h0,  1'b0, 16'b0_000_00000_000_00_1_0, ILL_CARE);
      push("ill2_hs", 1'b0, 1'b1, 6'h00, 11'h21, 1'b0, E_IDLE, ALL);
      push("ill2_dec",1'b0, 1'b0, 6'h00, 11'h0,  1'b0, 16'b0_000_00000_000_00_1_0, ILL_CARE);
      push("idle_end",1'b0, 1'b0, 6'h00, 11'h0,  1'b0, E_IDLE, ALL);

      for (int i = 0; i < vecs.size(); i++)
         cyc(vecs[i].name, vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].func,
             vecs[i].mrdy, vecs[i].exp, vecs[i].care);
      chk_cnt("cnt_after_table", 10, 3);

      // SW never gets mem_ready: 15 MEMORY cycles, mem_err on the last, no WRITEBACK.
      cyc("sw_hs",  1'b0, 1'b1, 6'h2B, 11'h0, 1'b0, E_IDLE, ALL);
      cyc("sw_dec", 1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_111_00000_000_00_0_0, ALL);
      cyc("sw_ex",  1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_11001_000_00_0_0, ALL);
      for (int k = 1; k <= 15; k++)
         cyc($sformatf("sw_m%0d", k), 1'b0, 1'b0, 6'h00, 11'h0, 1'b0,
             {1'b0, 3'b0, 5'b0, 3'b011, 2'b00, 1'b0, (k == 15)}, ALL);
      cyc("sw_abort_idle", 1'b0, 1'b0, 6'h00, 11'h0, 1'b0, E_IDLE, ALL);
      chk_cnt("cnt_after_sw", 10, 18);

      // LW: mem_ready arrives on the timeout cycle itself, so it completes normally.
      cyc("lwb_hs",  1'b0, 1'b1, 6'h23, 11'h0, 1'b0, E_IDLE, ALL);
      cyc("lwb_dec", 1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_101_00000_000_00_0_0, ALL);
      cyc("lwb_ex",  1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_11001_000_00_0_0, ALL);
      for (int k = 1; k <= 14; k++)
         cyc($sformatf("lwb_m%0d", k), 1'b0, 1'b0, 6'h00, 11'h0, 1'b0,
             16'b0_000_00000_101_00_0_0, ALL);
      cyc("lwb_m15_rdy", 1'b0, 1'b0, 6'h00, 11'h0, 1'b1, 16'b0_000_00000_101_00_0_0, ALL);
      cyc("lwb_wb",      1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_00000_000_11_0_0, ALL);
      cyc("lwb_idle",    1'b0, 1'b0, 6'h00, 11'h0, 1'b0, E_IDLE, ALL);
      chk_cnt("cnt_after_lw_boundary", 11, 32);

      // Reset in the middle of a LW stall, then an ORI runs cleanly.
      cyc("lwr_hs",  1'b0, 1'b1, 6'h23, 11'h0, 1'b0, E_IDLE, ALL);
      cyc("lwr_dec", 1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_101_00000_000_00_0_0, ALL);
      cyc("lwr_ex",  1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_11001_000_00_0_0, ALL);
      cyc("lwr_m1",  1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_00000_101_00_0_0, ALL);
      cyc("lwr_m2",  1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_00000_101_00_0_0, ALL);
      cyc("lwr_rst", 1'b1, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_00000_101_00_0_0, ALL);
      chk_cnt("cnt_after_rst", 0, 0);
      cyc("ori_hs",  1'b0, 1'b1, 6'h0D, 11'h0, 1'b0, E_IDLE, ALL);
      cyc("ori_dec", 1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_101_00000_000_00_0_0, ALL);
      cyc("ori_ex",  1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_11111_000_00_0_0, ALL);
      cyc("ori_mem", 1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_00000_001_00_0_0, ALL);
      cyc("ori_wb",  1'b0, 1'b0, 6'h00, 11'h0, 1'b0, 16'b0_000_00000_000_01_0_0, ALL);
      cyc("ori_idle",1'b0, 1'b0, 6'h00, 11'h0, 1'b0, E_IDLE, ALL);
      chk_cnt("cnt_after_ori", 1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
